// File: rtl/riscv_reset_sequencer.sv
// ---------------------------------------------------------------------------
// riscv_reset_sequencer
//
// Staged reset controller for the board top level. All reset domains are held
// in reset for HOLD_CYCLES. They are then released one at a time in index
// order, and each release waits until the previous domain reports ready. Any
// of the following re-runs the sequence from the start:
//   - a reset request,
//   - loss of ready on an already released domain,
//   - a domain that fails to become ready within TIMEOUT_CYCLES.
//
// Ports
//   clock         in   1           single clock
//   aresetn       in   1           asynchronous active-low reset
//   req_reset     in   1           synchronous request to re-run the sequence
//   stage_ready   in   NUM_STAGES  per-domain ready, asynchronous (3-flop sync)
//   stage_resetn  out  NUM_STAGES  per-domain active-low reset, registered
//   all_released  out  1           every domain released and ready (RUN)
//   busy          out  1           sequence in progress (not RUN)
//   cur_stage     out  3           index of the stage being waited on
//   timeout_err   out  1           sticky: some stage timed out since aresetn
// ---------------------------------------------------------------------------
module riscv_reset_sequencer #(
   parameter int NUM_STAGES     = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  aresetn,
   input  logic                  req_reset,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [NUM_STAGES-1:0] stage_resetn,
   output logic                  all_released,
   output logic                  busy,
   output logic [2:0]            cur_stage,
   output logic                  timeout_err
);

   localparam int MAX_CNT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(MAX_CNT) + 1;
   localparam int SW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_WAIT   = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SW-1:0]           cur_q, cur_d;
   logic [NUM_STAGES-1:0]   resetn_q, resetn_d;
   logic                    terr_q, terr_d;
   logic [NUM_STAGES-1:0]   sync1_q, sync2_q, rdy_q;
   logic [NUM_STAGES-1:0]   below_mask;
   logic                    ready_loss;
   logic                    abort;

   // State register, including the 3-flop ready synchronizer
   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ST_ASSERT;
         cnt_q    <= '0;
         cur_q    <= '0;
         resetn_q <= '0;
         terr_q   <= 1'b0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         rdy_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_q    <= cur_d;
         resetn_q <= resetn_d;
         terr_q   <= terr_d;
         sync1_q  <= stage_ready;
         sync2_q  <= sync1_q;
         rdy_q    <= sync2_q;
      end
   end

   // Stages below the current one are already released and must stay ready
   always_comb begin
      below_mask = '0;
      for (int j = 0; j < NUM_STAGES; j++) begin
         below_mask[j] = (j < int'(cur_q));
      end
   end

   always_comb begin
      ready_loss = 1'b0;
      if (state_q == ST_WAIT) begin
         ready_loss = |(~rdy_q & below_mask);
      end else if (state_q == ST_RUN) begin
         ready_loss = ~&rdy_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_d    = cur_q;
      resetn_d = resetn_q;
      terr_d   = terr_q;
      abort    = 1'b0;

      unique case (state_q)
         ST_ASSERT: begin
            if (req_reset) begin
               abort = 1'b1;
            end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               resetn_d = NUM_STAGES'(1);
               cnt_d    = '0;
               cur_d    = '0;
               state_d  = ST_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT: begin
            if (req_reset || ready_loss) begin
               abort = 1'b1;
            end else if (rdy_q[cur_q]) begin
               // Ready beats a timeout landing on the same edge
               cnt_d = '0;
               if (cur_q == SW'(NUM_STAGES - 1)) begin
                  state_d = ST_RUN;
               end else begin
                  // Released bits form a thermometer: shift in the next one
                  resetn_d = (resetn_q << 1) | NUM_STAGES'(1);
                  cur_d    = cur_q + SW'(1);
               end
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               terr_d = 1'b1;
               abort  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RUN: begin
            if (req_reset || ready_loss) begin
               abort = 1'b1;
            end
         end
         default: begin
            abort = 1'b1;
         end
      endcase

      // Every abort drops all domains together and restarts the hold count
      if (abort) begin
         state_d  = ST_ASSERT;
         resetn_d = '0;
         cnt_d    = '0;
         cur_d    = '0;
      end
   end

   // Outputs
   always_comb begin
      stage_resetn = resetn_q;
      all_released = (state_q == ST_RUN);
      busy         = (state_q != ST_RUN);
      cur_stage    = 3'(cur_q);
      timeout_err  = terr_q;
   end

endmodule

// File: tb/tb_riscv_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_riscv_reset_sequencer
//
// Directed bench for riscv_reset_sequencer with default parameters
// (4 stages, hold 16, timeout 1024). Edge numbers count rising clock edges
// after aresetn deasserts, starting at 1.
// ---------------------------------------------------------------------------
module tb_riscv_reset_sequencer;

   logic       clock;
   logic       aresetn;
   logic       req_reset;
   logic [3:0] stage_ready;
   logic [3:0] stage_resetn;
   logic       all_released;
   logic       busy;
   logic [2:0] cur_stage;
   logic       timeout_err;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   riscv_reset_sequencer #(
      .NUM_STAGES     (4),
      .HOLD_CYCLES    (16),
      .TIMEOUT_CYCLES (1024)
   ) dut (
      .clock        (clock),
      .aresetn      (aresetn),
      .req_reset    (req_reset),
      .stage_ready  (stage_ready),
      .stage_resetn (stage_resetn),
      .all_released (all_released),
      .busy         (busy),
      .cur_stage    (cur_stage),
      .timeout_err  (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int         edge_n;
      logic [3:0] ready;
      logic       req;
      logic [3:0] exp_resetn;
      logic       exp_all;
      logic       exp_busy;
      logic [2:0] exp_cur;
      logic       exp_terr;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] rn, input logic al,
                          input logic bz, input logic [2:0] cs, input logic te);
      chk({tag, ".stage_resetn"}, 32'(stage_resetn), 32'(rn));
      chk({tag, ".all_released"}, 32'(all_released), 32'(al));
      chk({tag, ".busy"},         32'(busy),         32'(bz));
      chk({tag, ".cur_stage"},    32'(cur_stage),    32'(cs));
      chk({tag, ".timeout_err"},  32'(timeout_err),  32'(te));
   endtask

   // Advance to 1 time unit after rising edge n
   task automatic step_to(input int n);
      while (edge_n < n) begin
         @(posedge clock);
         #1;
         edge_n++;
      end
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock edge
   task automatic do_reset(input string tag, input logic [3:0] rdy);
      #2;
      aresetn = 1'b0;
      #1;
      chk_all({tag, ".async"}, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0);
      req_reset   = 1'b0;
      stage_ready = rdy;
      repeat (2) @(posedge clock);
      @(negedge clock);
      aresetn = 1'b1;
      edge_n  = 0;
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 8; i++) begin
         stage_ready = tbl[i].ready;
         req_reset   = tbl[i].req;
         step_to(tbl[i].edge_n);
         chk_all($sformatf("%s[%0d]", tag, i), tbl[i].exp_resetn, tbl[i].exp_all,
                 tbl[i].exp_busy, tbl[i].exp_cur, tbl[i].exp_terr);
      end
   endtask

   initial begin
      // Static ready: stage k released at edge 16+k, RUN after edge 20
      tbl[0] = '{1,  4'hF, 1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0};
      tbl[1] = '{15, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0};
      tbl[2] = '{16, 4'hF, 1'b0, 4'h1, 1'b0, 1'b1, 3'd0, 1'b0};
      tbl[3] = '{17, 4'hF, 1'b0, 4'h3, 1'b0, 1'b1, 3'd1, 1'b0};
      tbl[4] = '{18, 4'hF, 1'b0, 4'h7, 1'b0, 1'b1, 3'd2, 1'b0};
      tbl[5] = '{19, 4'hF, 1'b0, 4'hF, 1'b0, 1'b1, 3'd3, 1'b0};
      tbl[6] = '{20, 4'hF, 1'b0, 4'hF, 1'b1, 1'b0, 3'd3, 1'b0};
      tbl[7] = '{25, 4'hF, 1'b0, 4'hF, 1'b1, 1'b0, 3'd3, 1'b0};

      aresetn     = 1'b1;
      req_reset   = 1'b0;
      stage_ready = 4'hF;

      // Basic sequence
      do_reset("t1", 4'hF);
      run_table("t1");

      // Ready loss in RUN: 1-cycle drop of ready[0]
      stage_ready = 4'hE;
      step_to(26);
      stage_ready = 4'hF;
      step_to(28);
      chk("t3.still_run", 32'(stage_resetn), 32'hF);
      step_to(29);
      chk_all("t3.abort", 4'h0, 1'b0, 1'b1, 3'd0, 1'b0);
      step_to(44);
      chk("t3.hold", 32'(stage_resetn), 32'h0);
      step_to(45);
      chk("t3.rel0", 32'(stage_resetn), 32'h1);
      step_to(49);
      chk_all("t3.run", 4'hF, 1'b1, 1'b0, 3'd3, 1'b0);

      // req_reset in WAIT(2), then again at hold count 10
      do_reset("t4", 4'h3);
      step_to(20);
      chk_all("t4.wait2", 4'h7, 1'b0, 1'b1, 3'd2, 1'b0);
      req_reset = 1'b1;
      step_to(21);
      req_reset = 1'b0;
      chk_all("t4.abort", 4'h0, 1'b0, 1'b1, 3'd0, 1'b0);
      step_to(31);
      req_reset = 1'b1;
      step_to(32);
      req_reset = 1'b0;
      step_to(37);
      chk("t4.restarted", 32'(stage_resetn), 32'h0);
      step_to(47);
      chk("t4.hold", 32'(stage_resetn), 32'h0);
      step_to(48);
      chk_all("t4.rel0", 4'h1, 1'b0, 1'b1, 3'd0, 1'b0);
      step_to(50);
      chk_all("t4.wait2b", 4'h7, 1'b0, 1'b1, 3'd2, 1'b0);

      // Ready[1] arrives on the same edge the timeout would fire (edge 1041)
      do_reset("t5", 4'h1);
      step_to(1037);
      stage_ready = 4'h3;
      step_to(1040);
      chk_all("t5.pre", 4'h3, 1'b0, 1'b1, 3'd1, 1'b0);
      step_to(1041);
      chk_all("t5.adv", 4'h7, 1'b0, 1'b1, 3'd2, 1'b0);

      // Timeout on stage 1, then recovery with timeout_err sticky
      do_reset("t2", 4'hD);
      step_to(1040);
      chk_all("t2.pre", 4'h3, 1'b0, 1'b1, 3'd1, 1'b0);
      step_to(1041);
      chk_all("t2.tmo", 4'h0, 1'b0, 1'b1, 3'd0, 1'b1);
      stage_ready = 4'hF;
      step_to(1056);
      chk("t2.hold", 32'(stage_resetn), 32'h0);
      step_to(1057);
      chk("t2.rel0", 32'(stage_resetn), 32'h1);
      step_to(1061);
      chk_all("t2.run", 4'hF, 1'b1, 1'b0, 3'd3, 1'b1);

      // Asynchronous reset in WAIT(3), then the same sequence again
      do_reset("t6a", 4'hF);
      step_to(19);
      chk_all("t6.wait3", 4'hF, 1'b0, 1'b1, 3'd3, 1'b0);
      do_reset("t6b", 4'hF);
      run_table("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
